// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: FSM encoding, bus widths, arbiter defaults.
// Also provides the two-master round-robin pick.
package mem_bus_pkg;
   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 32;
   localparam int TIMEOUT_DEF = 1023;
   localparam int CNT_W_DEF   = 10;
   localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              we;
      logic              rd;
   } bus_req_t;

   // On a tie the master that did not win last time gets the bus.
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      return (&req) ? ~last : req[1];
   endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One memory-bus port set (address/data/strobes toward the slave, data/ready/irq back).
// mst drives the request side, slv answers it.
interface mem_bus_arbiter_if;
   import mem_bus_pkg::*;

   logic [ADDR_W-1:0] a;
   logic [DATA_W-1:0] d;
   logic              we;
   logic              rd;
   logic [DATA_W-1:0] spo;
   logic              ready;
   logic              irq;

   modport mst (output a, d, we, rd, input  spo, ready, irq);
   modport slv (input  a, d, we, rd, output spo, ready, irq);
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// Saturating transaction watchdog: cleared at grant, counts while enabled,
// flags expiry in the cycle that would bring the count to TIMEOUT.
module bus_watchdog #(
   parameter int CNT_W   = 10,
   parameter int TIMEOUT = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired_o = en_i && (cnt_q >= CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the single memory bus. Each transaction
// holds the bus until the slave answers or the watchdog aborts it.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
   input  logic clk,
   input  logic rst_n,
   mem_bus_arbiter_if.slv m0,
   mem_bus_arbiter_if.slv m1,
   mem_bus_arbiter_if.mst s,
   output logic gnt,
   output logic busy
);
   bus_req_t [1:0]    req;
   logic     [1:0]    req_v;
   logic     [1:0]    rsp_v;
   state_e            state_q, state_d;
   logic              gnt_q, gnt_d;
   bus_req_t          out_q, out_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              sel;
   logic              wd_clr, wd_en, wd_exp;

   assign req[0] = {m0.a, m0.d, m0.we, m0.rd};
   assign req[1] = {m1.a, m1.d, m1.we, m1.rd};

   for (genvar i = 0; i < 2; i++) begin : g_mst
      assign req_v[i] = req[i].we | req[i].rd;
      assign rsp_v[i] = (state_q == RESP) && (gnt_q == (i != 0));
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      out_d   = out_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wd_clr  = 1'b0;
      wd_en   = 1'b0;
      sel     = rr_pick(req_v, gnt_q);
      case (state_q)
         IDLE: begin
            if (|req_v) begin
               gnt_d = sel;
               // Read+write together is refused without touching the slave.
               if (req[sel].we && req[sel].rd) begin
                  rdata_d = ERR_DATA;
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  out_d   = req[sel];
                  wd_clr  = 1'b1;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            wd_en = 1'b1;
            // s_ready is checked first so a late answer still beats the abort.
            if (s.ready) begin
               rdata_d  = s.spo;
               err_d    = s.irq;
               out_d.we = 1'b0;
               out_d.rd = 1'b0;
               state_d  = RESP;
            end else if (wd_exp) begin
               rdata_d  = ERR_DATA;
               err_d    = 1'b1;
               out_d.we = 1'b0;
               out_d.rd = 1'b0;
               state_d  = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 1'b1;
         out_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         out_q   <= out_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   bus_watchdog #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_wd (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (wd_clr),
      .en_i      (wd_en),
      .expired_o (wd_exp)
   );

   assign s.a  = out_q.a;
   assign s.d  = out_q.d;
   assign s.we = out_q.we;
   assign s.rd = out_q.rd;

   assign m0.ready = rsp_v[0];
   assign m0.spo   = rsp_v[0] ? rdata_q : '0;
   assign m0.irq   = rsp_v[0] & err_q;
   assign m1.ready = rsp_v[1];
   assign m1.spo   = rsp_v[1] ? rdata_q : '0;
   assign m1.irq   = rsp_v[1] & err_q;

   assign gnt  = gnt_q;
   assign busy = (state_q == ISSUE) || (state_q == RESP);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: scripted scenarios plus random traffic against a
// transaction-level model (grant order, response timing and payload).
module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   localparam int          TO   = 8;
   localparam logic [31:0] ERRD = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic gnt, busy;

   always #5 clk = ~clk;

   mem_bus_arbiter_if m0_if ();
   mem_bus_arbiter_if m1_if ();
   mem_bus_arbiter_if s_if ();

   mem_bus_arbiter #(.TIMEOUT(TO), .CNT_W(10), .ERR_DATA(ERRD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .m0    (m0_if),
      .m1    (m1_if),
      .s     (s_if),
      .gnt   (gnt),
      .busy  (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Slave-side expectation for each issued transaction, in model order.
   typedef struct {
      int          lat;
      logic [31:0] a;
      logic [31:0] d;
      logic        we;
      logic [31:0] data;
      logic        irq;
   } slv_t;
   slv_t slv_q[$];

   logic        rq_we[2], rq_rd[2];
   logic [31:0] rq_a[2], rq_d[2];
   int          tx_lat[2];
   logic [31:0] tx_data[2];
   logic        tx_irq[2];
   logic        mdl_gnt = 1'b1;

   task automatic drive_m(input int i, input bit on);
      if (i == 0) begin
         m0_if.a  = on ? rq_a[0] : 32'h0;
         m0_if.d  = on ? rq_d[0] : 32'h0;
         m0_if.we = on & rq_we[0];
         m0_if.rd = on & rq_rd[0];
      end else begin
         m1_if.a  = on ? rq_a[1] : 32'h0;
         m1_if.d  = on ? rq_d[1] : 32'h0;
         m1_if.we = on & rq_we[1];
         m1_if.rd = on & rq_rd[1];
      end
   endtask

   task automatic set_tx(input int i, input logic we, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input int lat, input logic [31:0] data,
                         input logic irq);
      rq_we[i] = we; rq_rd[i] = rd; rq_a[i] = a; rq_d[i] = d;
      tx_lat[i] = lat; tx_data[i] = data; tx_irq[i] = irq;
   endtask

   // Slave: answers in the lat-th strobe cycle (lat=0 never answers).
   initial begin : slave_model
      int   k;
      slv_t cur;
      k = 0;
      cur = '{default: 0};
      s_if.ready = 1'b0; s_if.spo = 32'h0; s_if.irq = 1'b0;
      forever begin
         @(negedge clk);
         if (s_if.rd | s_if.we) begin
            if (k == 0) begin
               n_cmp++;
               if (slv_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL unexpected_strobe: a=%h we=%b rd=%b, want no strobe",
                           s_if.a, s_if.we, s_if.rd);
                  cur = '{default: 0};
               end else begin
                  cur = slv_q.pop_front();
                  if (s_if.a !== cur.a || s_if.d !== cur.d || s_if.we !== cur.we ||
                      s_if.rd !== !cur.we) begin
                     n_bad++;
                     $display("FAIL slave_cmd: a=%h d=%h we=%b rd=%b, want a=%h d=%h we=%b rd=%b",
                              s_if.a, s_if.d, s_if.we, s_if.rd, cur.a, cur.d, cur.we, !cur.we);
                  end
               end
            end
            k++;
            if (k == cur.lat) begin
               s_if.ready = 1'b1; s_if.spo = cur.data; s_if.irq = cur.irq;
            end else begin
               s_if.ready = 1'b0; s_if.spo = 32'h0; s_if.irq = 1'b0;
            end
         end else begin
            k = 0;
            s_if.ready = 1'b0; s_if.spo = 32'h0; s_if.irq = 1'b0;
         end
      end
   end

   // Presents the requests of the masters in act, predicts order/timing/payload
   // from the arbitration rules, and checks every master-side cycle.
   task automatic run_pair(input bit [1:0] act, input string nm);
      int          ord[2];
      int          n, c, cyc, m;
      int          exp_at[2];
      logic [31:0] exp_spo[2];
      logic        exp_irq[2];
      bit          done[2];
      logic [1:0]  rdy, irq;
      logic [31:0] spo[2];
      n = 0;
      if (act == 2'b11) begin
         ord[0] = mdl_gnt ? 0 : 1;
         ord[1] = mdl_gnt ? 1 : 0;
         n = 2;
      end else begin
         ord[0] = act[1] ? 1 : 0;
         ord[1] = 0;
         n = 1;
      end
      done[0] = 1; done[1] = 1;
      for (int j = 0; j < n; j++) begin
         m = ord[j];
         done[m] = 0;
         if (rq_we[m] && rq_rd[m]) begin
            cyc = 1; exp_spo[m] = ERRD; exp_irq[m] = 1'b1;
         end else begin
            slv_q.push_back('{tx_lat[m], rq_a[m], rq_d[m], rq_we[m], tx_data[m], tx_irq[m]});
            if (tx_lat[m] >= 1 && tx_lat[m] <= TO) begin
               cyc = tx_lat[m] + 1; exp_spo[m] = tx_data[m]; exp_irq[m] = tx_irq[m];
            end else begin
               cyc = TO + 1; exp_spo[m] = ERRD; exp_irq[m] = 1'b1;
            end
         end
         exp_at[m] = (j == 0) ? cyc : exp_at[ord[0]] + 1 + cyc;
         mdl_gnt = (m == 1);
      end
      @(negedge clk);
      drive_m(0, act[0]);
      drive_m(1, act[1]);
      c = 0;
      while (!(done[0] && done[1]) && c < 40) begin
         @(negedge clk);
         c++;
         rdy = {m1_if.ready, m0_if.ready};
         irq = {m1_if.irq, m0_if.irq};
         spo[0] = m0_if.spo; spo[1] = m1_if.spo;
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (rdy[i]) begin
               if (done[i] || c != exp_at[i] || spo[i] !== exp_spo[i] ||
                   irq[i] !== exp_irq[i] || gnt !== (i == 1)) begin
                  n_bad++;
                  $display("FAIL %s m%0d rsp: got cyc=%0d spo=%h irq=%b gnt=%b, want cyc=%0d spo=%h irq=%b gnt=%0d pending=%0d",
                           nm, i, c, spo[i], irq[i], gnt, exp_at[i], exp_spo[i], exp_irq[i], i, !done[i]);
               end
               done[i] = 1;
               drive_m(i, 0);
            end else if (spo[i] !== 32'h0 || irq[i] !== 1'b0) begin
               n_bad++;
               $display("FAIL %s m%0d idle: got spo=%h irq=%b, want 0", nm, i, spo[i], irq[i]);
            end
         end
      end
      if (!(done[0] && done[1])) begin
         n_cmp++; n_bad++;
         $display("FAIL %s no_response: got done=%0d%0d after %0d cycles, want both", nm,
                  done[1], done[0], c);
         drive_m(0, 0); drive_m(1, 0);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || s_if.rd !== 1'b0 || s_if.we !== 1'b0) begin
         n_bad++;
         $display("FAIL %s idle_after: got busy=%b rd=%b we=%b, want 0", nm, busy, s_if.rd, s_if.we);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) set_tx(i, 0, 0, 0, 0, 1, 0, 0);
      drive_m(0, 0); drive_m(1, 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (m0_if.ready !== 0 || m0_if.irq !== 0 || m0_if.spo !== 0 ||
          m1_if.ready !== 0 || m1_if.irq !== 0 || m1_if.spo !== 0) begin
         n_bad++;
         $display("FAIL reset_mst: got rdy=%b%b irq=%b%b spo=%h/%h, want 0", m1_if.ready,
                  m0_if.ready, m1_if.irq, m0_if.irq, m1_if.spo, m0_if.spo);
      end
      n_cmp++;
      if (s_if.a !== 0 || s_if.d !== 0 || s_if.we !== 0 || s_if.rd !== 0) begin
         n_bad++;
         $display("FAIL reset_slv: got a=%h d=%h we=%b rd=%b, want 0", s_if.a, s_if.d, s_if.we, s_if.rd);
      end
      n_cmp++;
      if (gnt !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctl: got gnt=%b busy=%b, want gnt=1 busy=0", gnt, busy);
      end
      rst_n = 1'b1;
      mdl_gnt = 1'b1;
   endtask

   task automatic test_contention();
      for (int r = 0; r < 3; r++) begin
         set_tx(0, 1, 0, 32'h2000_0000 + r, $urandom, 1, $urandom, 0);
         set_tx(1, 0, 1, 32'h3000_0000 + r, $urandom, 2, $urandom, 0);
         run_pair(2'b11, "contention");
      end
   endtask

   task automatic test_single_read();
      set_tx(0, 0, 1, 32'h1000_0040, 32'h0, 2, 32'hCAFE_F00D, 0);
      run_pair(2'b01, "single_read");
   endtask

   task automatic test_timeout();
      set_tx(1, 0, 1, 32'h4000_0100, 32'h0, 0, 32'h1234_5678, 0);
      run_pair(2'b10, "timeout");
   endtask

   task automatic test_illegal();
      set_tx(0, 1, 1, 32'h5000_0000, 32'hDEAD_BEEF, 1, 32'h1111_1111, 0);
      run_pair(2'b01, "illegal");
   endtask

   task automatic test_slave_err();
      set_tx(0, 1, 0, 32'h6000_0004, 32'hA5A5_A5A5, 1, 32'h7777_0000, 1);
      run_pair(2'b01, "slave_err");
      set_tx(0, 0, 1, 32'h6000_0008, 32'h0, TO, 32'h8888_0001, 1);
      run_pair(2'b01, "tie_irq1");
      set_tx(1, 0, 1, 32'h6000_000C, 32'h0, TO, 32'h9999_0002, 0);
      run_pair(2'b10, "tie_irq0");
   endtask

   task automatic test_random();
      int kind, r;
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < 2; i++) begin
            kind = $urandom_range(0, 7);
            r = $urandom_range(0, 9);
            set_tx(i, kind <= 3, (kind == 0) || (kind > 3), $urandom, $urandom,
                   (r == 0) ? 0 : (r == 9) ? TO : (r % 4) + 1, $urandom,
                   $urandom_range(0, 3) == 0);
         end
         run_pair(2'($urandom_range(1, 3)), "random");
      end
   endtask

   task automatic test_async_reset();
      set_tx(0, 0, 1, 32'h7000_0000, 32'h0, 0, 32'h0, 0);
      slv_q.push_back('{0, rq_a[0], rq_d[0], 1'b0, 32'h0, 1'b0});
      @(negedge clk);
      drive_m(0, 1);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (s_if.rd !== 1'b0 || s_if.we !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset_drop: got rd=%b we=%b busy=%b, want 0", s_if.rd, s_if.we, busy);
      end
      drive_m(0, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if (m0_if.ready !== 1'b0 || m1_if.ready !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_rsp: got rdy=%b%b, want 00", m1_if.ready, m0_if.ready);
         end
      end
      rst_n = 1'b1;
      mdl_gnt = 1'b1;
      slv_q.delete();
      set_tx(0, 0, 1, 32'h7100_0000, 32'h0, 1, 32'h0BAD_CAFE, 0);
      set_tx(1, 1, 0, 32'h7200_0000, 32'h5555_AAAA, 1, 32'h0, 0);
      run_pair(2'b11, "post_reset");
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single_read();
      test_timeout();
      test_illegal();
      test_slave_err();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
